gcm_lane_framer: RTL and testbench

- Parametrised front/back-end wrapper that feeds NUM_LANES independent GCM AES cores from one packet word stream, and realigns their cipher output with the sideband (bypass) data.
- Tracks word position inside each packet (first/second/inner) and derives the plaintext bit size from the header length field.
- Latches a per-packet size and mode, and delays sideband, position and mode through a CORE_LAT-deep pipeline to match core latency.
- Adds a per-packet cleartext bypass mode, a lane-ready mismatch check and a packet word counter.

---
 rtl/gcm_lane_pkg.sv | 29 ++
 rtl/gcm_lane_framer_delay.sv | 27 ++
 rtl/gcm_lane_framer.sv | 160 ++++++++++++++++
 tb/tb_gcm_lane_framer.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcm_lane_pkg.sv
// Shared constants and helpers for the GCM lane framer.
// Position encodings double as the position FSM state values.
package gcm_lane_pkg;

    localparam int AES_BLK_W = 128;
    localparam int LEN_W     = 16;

    localparam logic [2:0] POS_FIRST  = 3'b001;
    localparam logic [2:0] POS_SECOND = 3'b010;
    localparam logic [2:0] POS_INNER  = 3'b100;

    typedef enum logic [2:0] {
        ST_FIRST  = POS_FIRST,
        ST_SECOND = POS_SECOND,
        ST_INNER  = POS_INNER
    } pos_state_e;

    // len bytes to plaintext bits, minus header, clamped at zero
    function automatic logic [63:0] sat_pt_size(
        input logic [LEN_W-1:0] len,
        input logic [63:0]      hdr
    );
        logic [63:0] bits;
        bits = {45'd0, len, 3'd0};
        if (bits < hdr) return 64'd0;
        return bits - hdr;
    endfunction

endpackage

// File: rtl/gcm_lane_framer_delay.sv
// Fixed-depth shift register with synchronous clear.
// Used to hold sideband words while the cores compute.
module gcm_side_delay #(
    parameter int DEPTH = 10,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] pipe_q [DEPTH];

    // shift one stage per cycle; reset drops everything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/gcm_lane_framer.sv
// Feeds NUM_LANES GCM cores from one packet stream and realigns
// their ciphertext with the delayed sideband.
module gcm_lane_framer
    import gcm_lane_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int SIDE_W    = 289,
    parameter int LEN_LSB   = 33,
    parameter int HDR_BITS  = 112,
    parameter int CORE_LAT  = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_valid,
    input  logic                           i_last,
    input  logic                           i_bypass,
    input  logic [AES_BLK_W*NUM_LANES-1:0] i_data,
    input  logic [SIDE_W-1:0]              i_side,
    output logic                           o_core_new,
    output logic                           o_core_last,
    output logic [AES_BLK_W*NUM_LANES-1:0] o_core_pt,
    output logic [63:0]                    o_core_pt_size,
    input  logic [NUM_LANES-1:0]           i_core_ready,
    input  logic [AES_BLK_W*NUM_LANES-1:0] i_core_ct,
    output logic                           o_valid,
    output logic                           o_last,
    output logic [2:0]                     o_pos,
    output logic [AES_BLK_W*NUM_LANES-1:0] o_data,
    output logic [SIDE_W-1:0]              o_side,
    output logic [LEN_W-1:0]               o_wcnt,
    output logic                           o_err
);

    localparam int DW  = AES_BLK_W * NUM_LANES;
    localparam int DLW = DW + SIDE_W + LEN_W + 6;

    pos_state_e       state_q, state_d;
    logic             mode_q, mode_d;
    logic [63:0]      size_q, size_d;
    logic [LEN_W-1:0] wcnt_q, wcnt_d;

    logic             at_first, first_word, mode_eff;
    logic [LEN_W-1:0] wcnt_cur;
    logic [63:0]      size_new;
    logic [DLW-1:0]   dly_d, dly_q;

    logic             d_valid, d_last, d_mode;
    logic [2:0]       d_pos;
    logic [LEN_W-1:0] d_wcnt;
    logic [SIDE_W-1:0] d_side;
    logic [DW-1:0]    d_data;
    logic             mismatch;

    logic             valid_q, last_q, err_q;
    logic [2:0]       pos_q;
    logic [LEN_W-1:0] owcnt_q;
    logic [DW-1:0]    data_q;
    logic [SIDE_W-1:0] side_q;

    // position FSM, per-packet latches and the input-side strobes
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        size_d   = size_q;
        wcnt_d   = wcnt_q;
        at_first = (state_q == ST_FIRST);
        first_word = i_valid && at_first;
        size_new = sat_pt_size(i_side[LEN_LSB +: LEN_W], 64'(HDR_BITS));
        mode_eff = first_word ? i_bypass : mode_q;
        wcnt_cur = at_first ? '0 : wcnt_q;
        if (i_valid) begin
            unique case (state_q)
                ST_FIRST:  state_d = i_last ? ST_FIRST : ST_SECOND;
                ST_SECOND: state_d = i_last ? ST_FIRST : ST_INNER;
                ST_INNER:  state_d = i_last ? ST_FIRST : ST_INNER;
                default:   state_d = ST_FIRST;
            endcase
            wcnt_d = (wcnt_cur == '1) ? wcnt_cur : wcnt_cur + 1'b1;
        end
        if (first_word) begin
            mode_d = i_bypass;
            size_d = size_new;
        end
        o_core_new     = i_valid & ~mode_eff;
        o_core_last    = i_last & o_core_new;
        o_core_pt      = i_data;
        o_core_pt_size = first_word ? size_new : size_q;
        dly_d = '0;
        if (i_valid) begin
            dly_d = {1'b1, i_last, 3'(state_q), wcnt_cur, mode_eff,
                     i_side, mode_eff ? i_data : {DW{1'b0}}};
        end
    end

    // packet tracking state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FIRST;
            mode_q  <= 1'b0;
            size_q  <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            size_q  <= size_d;
            wcnt_q  <= wcnt_d;
        end
    end

    gcm_side_delay #(
        .DEPTH (CORE_LAT),
        .WIDTH (DLW)
    ) u_delay (
        .clk (clk),
        .rst (rst),
        .d_i (dly_d),
        .q_o (dly_q)
    );

    assign {d_valid, d_last, d_pos, d_wcnt, d_mode, d_side, d_data} = dly_q;

    // cores must report all lanes exactly when a cipher word is due
    always_comb begin
        mismatch = 1'b0;
        if (d_valid && !d_mode) mismatch = (i_core_ready != '1);
        else                    mismatch = (i_core_ready != '0);
    end

    // output register: merge delayed sideband with cipher or bypass data
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            pos_q   <= POS_FIRST;
            owcnt_q <= '0;
            data_q  <= '0;
            side_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= d_valid;
            last_q  <= d_valid & d_last;
            if (d_valid) begin
                pos_q   <= d_pos;
                owcnt_q <= d_wcnt;
                side_q  <= d_side;
                data_q  <= d_mode ? d_data : i_core_ct;
            end
            err_q <= err_q | mismatch;
        end
    end

    assign o_valid = valid_q;
    assign o_last  = last_q;
    assign o_pos   = pos_q;
    assign o_wcnt  = owcnt_q;
    assign o_data  = data_q;
    assign o_side  = side_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_gcm_lane_framer.sv
// Randomised bench for gcm_lane_framer with a packet-level reference
// model and a fixed-latency XOR core model.
module tb_gcm_lane_framer;

    localparam int NL  = 2;
    localparam int SW  = 289;
    localparam int LL  = 33;
    localparam int HB  = 112;
    localparam int LAT = 10;
    localparam int DW  = 128 * NL;
    localparam logic [DW-1:0] KEYS = {128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0,
                                      128'h13579bdf02468ace_fdb97531eca86420};

    logic          clk = 1'b0;
    logic          rst, i_valid, i_last, i_bypass;
    logic [DW-1:0] i_data, o_core_pt, i_core_ct, o_data;
    logic [SW-1:0] i_side, o_side;
    logic          o_core_new, o_core_last, o_valid, o_last, o_err;
    logic [63:0]   o_core_pt_size;
    logic [NL-1:0] i_core_ready;
    logic [2:0]    o_pos;
    logic [15:0]   o_wcnt;

    gcm_lane_framer #(
        .NUM_LANES (NL),
        .SIDE_W    (SW),
        .LEN_LSB   (LL),
        .HDR_BITS  (HB),
        .CORE_LAT  (LAT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_valid        (i_valid),
        .i_last         (i_last),
        .i_bypass       (i_bypass),
        .i_data         (i_data),
        .i_side         (i_side),
        .o_core_new     (o_core_new),
        .o_core_last    (o_core_last),
        .o_core_pt      (o_core_pt),
        .o_core_pt_size (o_core_pt_size),
        .i_core_ready   (i_core_ready),
        .i_core_ct      (i_core_ct),
        .o_valid        (o_valid),
        .o_last         (o_last),
        .o_pos          (o_pos),
        .o_data         (o_data),
        .o_side         (o_side),
        .o_wcnt         (o_wcnt),
        .o_err          (o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst, vld, last, byp, drop;
        logic [DW-1:0] data;
        logic [SW-1:0] side;
        logic          exp_new;
        logic [63:0]   exp_size;
        logic [2:0]    pos;
        logic [15:0]   wcnt;
        logic [DW-1:0] exp_data;
    } stim_t;

    typedef struct {
        logic          last;
        logic [2:0]    pos;
        logic [15:0]   wcnt;
        logic [DW-1:0] data;
        logic [SW-1:0] side;
        int            due;
    } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];

    logic          core_v [LAT];
    logic [NL-1:0] core_r [LAT];
    logic [DW-1:0] core_c [LAT];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic          obs_new, obs_clast;
    logic [63:0]   obs_size;
    logic [DW-1:0] obs_pt;

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [SW-1:0] rnd_side();
        logic [319:0] r;
        for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
        return r[SW-1:0];
    endfunction

    function automatic logic [63:0] ref_size(input int len);
        longint b;
        b = longint'(len) * 8 - HB;
        return (b < 0) ? 64'd0 : 64'(b);
    endfunction

    function automatic stim_t idle_stim();
        stim_t s;
        s = '{default: '0};
        s.last = 1'($urandom);
        s.byp  = 1'($urandom);
        s.data = rnd_data();
        s.side = rnd_side();
        return s;
    endfunction

    task automatic build_pkt(input int n, input int len, input logic byp,
                             input int drop_at, input logic use_pat,
                             input logic [DW-1:0] pat);
        stim_t s;
        for (int i = 0; i < n; i++) begin
            s = '{default: '0};
            s.vld  = 1'b1;
            s.last = (i == n - 1);
            s.byp  = (i == 0) ? byp : ~byp;
            s.drop = (i == drop_at);
            s.data = use_pat ? pat : rnd_data();
            s.side = rnd_side();
            if (i == 0) s.side[LL +: 16] = len[15:0];
            s.exp_new  = ~byp;
            s.exp_size = ref_size(len);
            s.pos  = (i == 0) ? 3'b001 : (i == 1) ? 3'b010 : 3'b100;
            s.wcnt = 16'(i);
            s.exp_data = byp ? s.data : (s.data ^ KEYS);
            stim_q.push_back(s);
        end
    endtask

    // one clock: drive inputs, advance the core model, land on negedge
    task automatic step(input stim_t s);
        rst      = s.rst;
        i_valid  = s.vld;
        i_last   = s.last;
        i_bypass = s.byp;
        i_data   = s.data;
        i_side   = s.side;
        #1;
        obs_new   = o_core_new;
        obs_clast = o_core_last;
        obs_size  = o_core_pt_size;
        obs_pt    = o_core_pt;
        if (s.vld && !s.rst)
            exp_q.push_back('{s.last, s.pos, s.wcnt, s.exp_data, s.side,
                              cyc + LAT + 1});
        @(posedge clk);
        cyc++;
        if (s.rst) begin
            for (int i = 0; i < LAT; i++) begin
                core_v[i] = 1'b0;
                core_r[i] = '0;
                core_c[i] = '0;
            end
        end else begin
            for (int i = LAT - 1; i > 0; i--) begin
                core_v[i] = core_v[i-1];
                core_r[i] = core_r[i-1];
                core_c[i] = core_c[i-1];
            end
            core_v[0] = obs_new;
            core_r[0] = s.drop ? ~(NL'(1) << 1) : '1;
            core_c[0] = obs_pt ^ KEYS;
        end
        #1;
        i_core_ready = core_v[LAT-1] ? core_r[LAT-1] : '0;
        i_core_ct    = core_v[LAT-1] ? core_c[LAT-1] : '0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        stim_t s;
        s = idle_stim();
        s.rst = 1'b1;
        step(s);
    endtask

    task automatic test_reset();
        do_reset();
        do_reset();
        total++;
        if ({o_valid, o_last, o_pos, o_wcnt, o_err} !== {1'b0, 1'b0, 3'b001, 16'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_ctl got v=%b l=%b pos=%b w=%0d e=%b want 0 0 001 0 0",
                     o_valid, o_last, o_pos, o_wcnt, o_err);
        end
        total++;
        if (o_data !== '0 || o_side !== '0) begin
            bad++;
            $display("FAIL reset_data got data=%h want 0", o_data);
        end
        step(idle_stim());
        total++;
        if (obs_new !== 1'b0 || obs_size !== 64'd0 || o_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset got new=%b size=%0d v=%b want 0 0 0",
                     obs_new, obs_size, o_valid);
        end
    endtask

    task automatic test_three_word();
        stim_t s;
        exp_t  e;
        int    budget;
        build_pkt(3, 64, 1'b0, -1, 1'b0, '0);
        budget = 60;
        while ((stim_q.size() != 0 || exp_q.size() != 0) && budget > 0) begin
            budget--;
            s = (stim_q.size() != 0) ? stim_q.pop_front() : idle_stim();
            step(s);
            if (s.vld) begin
                total++;
                if (obs_size !== 64'd400 || obs_new !== 1'b1 || obs_clast !== s.last) begin
                    bad++;
                    $display("FAIL three_core got size=%0d new=%b last=%b want 400 1 %b",
                             obs_size, obs_new, obs_clast, s.last);
                end
            end
            if (o_valid) begin
                total++;
                e = exp_q.pop_front();
                if ({o_last, o_pos, o_wcnt, o_data, o_side, o_err} !==
                    {e.last, e.pos, e.wcnt, e.data, e.side, 1'b0} || cyc != e.due) begin
                    bad++;
                    $display("FAIL three_out got pos=%b w=%0d l=%b e=%b cyc=%0d want pos=%b w=%0d l=%b cyc=%0d",
                             o_pos, o_wcnt, o_last, o_err, cyc, e.pos, e.wcnt, e.last, e.due);
                end
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL three_timeout got pending=%0d want 0", exp_q.size());
        end
    endtask

    task automatic test_size_edges();
        stim_t s;
        exp_t  e;
        int    budget;
        build_pkt(1, 14, 1'b0, -1, 1'b0, '0);
        build_pkt(2, 10, 1'b0, -1, 1'b0, '0);
        build_pkt(2, 15, 1'b0, -1, 1'b0, '0);
        build_pkt(1, 65535, 1'b0, -1, 1'b0, '0);
        budget = 60;
        while ((stim_q.size() != 0 || exp_q.size() != 0) && budget > 0) begin
            budget--;
            s = (stim_q.size() != 0) ? stim_q.pop_front() : idle_stim();
            step(s);
            if (s.vld) begin
                total++;
                if (obs_size !== s.exp_size || obs_new !== 1'b1) begin
                    bad++;
                    $display("FAIL size_edge got size=%0d new=%b want %0d 1",
                             obs_size, obs_new, s.exp_size);
                end
            end
            if (o_valid) begin
                total++;
                e = exp_q.pop_front();
                if ({o_last, o_pos, o_wcnt, o_data, o_side} !==
                    {e.last, e.pos, e.wcnt, e.data, e.side} || cyc != e.due) begin
                    bad++;
                    $display("FAIL size_out got pos=%b w=%0d l=%b cyc=%0d want pos=%b w=%0d l=%b cyc=%0d",
                             o_pos, o_wcnt, o_last, cyc, e.pos, e.wcnt, e.last, e.due);
                end
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL size_timeout got pending=%0d want 0", exp_q.size());
        end
    endtask

    task automatic test_bypass();
        stim_t s;
        exp_t  e;
        int    budget;
        build_pkt(2, 64, 1'b1, -1, 1'b1, {16{16'hA5A5}});
        build_pkt(2, 40, 1'b0, -1, 1'b0, '0);
        budget = 60;
        while ((stim_q.size() != 0 || exp_q.size() != 0) && budget > 0) begin
            budget--;
            s = (stim_q.size() != 0) ? stim_q.pop_front() : idle_stim();
            step(s);
            if (s.vld) begin
                total++;
                if (obs_new !== s.exp_new || obs_pt !== s.data) begin
                    bad++;
                    $display("FAIL bypass_core got new=%b want %b", obs_new, s.exp_new);
                end
            end
            if (o_valid) begin
                total++;
                e = exp_q.pop_front();
                if ({o_last, o_pos, o_wcnt, o_data, o_side, o_err} !==
                    {e.last, e.pos, e.wcnt, e.data, e.side, 1'b0} || cyc != e.due) begin
                    bad++;
                    $display("FAIL bypass_out got data=%h e=%b cyc=%0d want data=%h cyc=%0d",
                             o_data, o_err, cyc, e.data, e.due);
                end
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL bypass_timeout got pending=%0d want 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        stim_t s;
        exp_t  e;
        int    budget, len;
        for (int p = 0; p < 30; p++) begin
            len = $urandom_range(0, 1) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 65535));
            build_pkt($urandom_range(1, 5), len, 1'($urandom_range(0, 3) == 0), -1, 1'b0, '0);
            if (p % 3 == 0) stim_q.push_back(idle_stim());
        end
        budget = 400;
        while ((stim_q.size() != 0 || exp_q.size() != 0) && budget > 0) begin
            budget--;
            s = (stim_q.size() != 0) ? stim_q.pop_front() : idle_stim();
            step(s);
            if (s.vld) begin
                total++;
                if (obs_new !== s.exp_new || obs_size !== s.exp_size ||
                    obs_clast !== (s.last & s.exp_new)) begin
                    bad++;
                    $display("FAIL b2b_core got new=%b size=%0d cl=%b want %b %0d %b",
                             obs_new, obs_size, obs_clast, s.exp_new, s.exp_size,
                             s.last & s.exp_new);
                end
            end
            if (o_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_spurious got o_valid=1 want 0");
                end else begin
                    e = exp_q.pop_front();
                    if ({o_last, o_pos, o_wcnt, o_data, o_side, o_err} !==
                        {e.last, e.pos, e.wcnt, e.data, e.side, 1'b0} || cyc != e.due) begin
                        bad++;
                        $display("FAIL b2b_out got pos=%b w=%0d l=%b e=%b cyc=%0d want pos=%b w=%0d l=%b cyc=%0d",
                                 o_pos, o_wcnt, o_last, o_err, cyc, e.pos, e.wcnt, e.last, e.due);
                    end
                end
            end
        end
        total++;
        if (exp_q.size() != 0 || stim_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_timeout got pending=%0d want 0", exp_q.size());
        end
    endtask

    task automatic test_lane_drop();
        stim_t s;
        exp_t  e;
        int    budget;
        build_pkt(3, 64, 1'b0, 1, 1'b0, '0);
        budget = 60;
        while ((stim_q.size() != 0 || exp_q.size() != 0) && budget > 0) begin
            budget--;
            s = (stim_q.size() != 0) ? stim_q.pop_front() : idle_stim();
            step(s);
            if (o_valid) begin
                total++;
                e = exp_q.pop_front();
                if (o_err !== (e.wcnt >= 16'd1) || o_data !== e.data || o_wcnt !== e.wcnt) begin
                    bad++;
                    $display("FAIL drop_err got err=%b w=%0d want err=%b w=%0d",
                             o_err, o_wcnt, e.wcnt >= 16'd1, e.wcnt);
                end
            end
        end
        for (int i = 0; i < 3; i++) step(idle_stim());
        total++;
        if (o_err !== 1'b1 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL drop_sticky got err=%b want 1", o_err);
        end
        do_reset();
        step(idle_stim());
        total++;
        if (o_err !== 1'b0) begin
            bad++;
            $display("FAIL drop_clear got err=%b want 0", o_err);
        end
    endtask

    task automatic test_reset_mid_packet();
        stim_t s;
        exp_t  e;
        int    budget;
        build_pkt(4, 64, 1'b0, -1, 1'b0, '0);
        step(stim_q.pop_front());
        step(stim_q.pop_front());
        stim_q.delete();
        do_reset();
        exp_q.delete();
        for (int i = 0; i < LAT + 1; i++) begin
            step(idle_stim());
            total++;
            if (o_valid !== 1'b0) begin
                bad++;
                $display("FAIL rst_flush got o_valid=%b want 0 at %0d", o_valid, i);
            end
        end
        build_pkt(2, 30, 1'b0, -1, 1'b0, '0);
        budget = 60;
        while ((stim_q.size() != 0 || exp_q.size() != 0) && budget > 0) begin
            budget--;
            s = (stim_q.size() != 0) ? stim_q.pop_front() : idle_stim();
            step(s);
            if (o_valid) begin
                total++;
                e = exp_q.pop_front();
                if ({o_last, o_pos, o_wcnt, o_data, o_side, o_err} !==
                    {e.last, e.pos, e.wcnt, e.data, e.side, 1'b0} || cyc != e.due) begin
                    bad++;
                    $display("FAIL rst_next got pos=%b w=%0d e=%b cyc=%0d want pos=%b w=%0d cyc=%0d",
                             o_pos, o_wcnt, o_err, cyc, e.pos, e.wcnt, e.due);
                end
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL rst_timeout got pending=%0d want 0", exp_q.size());
        end
    endtask

    initial begin
        rst          = 1'b1;
        i_valid      = 1'b0;
        i_last       = 1'b0;
        i_bypass     = 1'b0;
        i_data       = '0;
        i_side       = '0;
        i_core_ready = '0;
        i_core_ct    = '0;
        @(negedge clk);
        test_reset();
        test_three_word();
        test_size_edges();
        test_bypass();
        test_back_to_back();
        test_lane_drop();
        test_reset_mid_packet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
